// File: rtl/lake_sched_addr_ctrl.sv
// ---------------------------------------------------------------------------
// LakeSchedAddrCtrl
//
// This block generates the schedule and addresses for one memory port.
// It walks a loop nest of up to DIMS levels. A free-running cycle counter
// is compared against the schedule time of the current iteration point.
// When the two match, the block strobes step_o and presents the address of
// that point on addr_o.
//
// The schedule and address follow an affine form over the loop iterators:
//    sched = cycle_start + sum(iter_d * cycle_stride_d)
//    addr  = addr_start  + sum(iter_d * addr_stride_d)
// The block does not multiply. It keeps one accumulated offset per
// dimension and updates each offset incrementally, so the values stay
// exact modulo the field widths.
//
// Ports
//    clk_i                    single clock, rising edge
//    rst_n_i                  synchronous active-low reset
//    flush_i                  synchronous restart to IDLE
//    config_enable_i          enables sequencing; low holds IDLE
//    config_dimensionality_i  active loop depth 1..DIMS, 0 = idle
//    config_extent_<d>_i      iteration count of dim d (0 treated as 1)
//    config_cycle_start_i     cycle offset of the first step
//    config_cycle_stride_<d>_i schedule stride of dim d
//    config_addr_start_i      address of the first step
//    config_addr_stride_<d>_i address stride of dim d
//    step_o                   access strobe for this cycle
//    addr_o                   address, valid while step_o is high
//    last_o                   final step of the loop nest
//    done_o                   sticky completion flag
// ---------------------------------------------------------------------------
module lake_sched_addr_ctrl #(
    parameter int DIMS       = 3,
    parameter int CNT_WIDTH  = 16,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  config_enable_i,
    input  logic [1:0]            config_dimensionality_i,
    input  logic [CNT_WIDTH-1:0]  config_extent_0_i,
    input  logic [CNT_WIDTH-1:0]  config_extent_1_i,
    input  logic [CNT_WIDTH-1:0]  config_extent_2_i,
    input  logic [CNT_WIDTH-1:0]  config_cycle_start_i,
    input  logic [CNT_WIDTH-1:0]  config_cycle_stride_0_i,
    input  logic [CNT_WIDTH-1:0]  config_cycle_stride_1_i,
    input  logic [CNT_WIDTH-1:0]  config_cycle_stride_2_i,
    input  logic [ADDR_WIDTH-1:0] config_addr_start_i,
    input  logic [ADDR_WIDTH-1:0] config_addr_stride_0_i,
    input  logic [ADDR_WIDTH-1:0] config_addr_stride_1_i,
    input  logic [ADDR_WIDTH-1:0] config_addr_stride_2_i,
    output logic                  step_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o,
    output logic                  done_o
);

    // The configuration ports are enumerated individually. The nest can
    // therefore never be deeper than the number of port triples, even if
    // DIMS is set larger.
    localparam int NPORT = 3;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cycCnt_q, cycCnt_d;
    logic [CNT_WIDTH-1:0]  sched_q, sched_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  done_q, done_d;
    logic [CNT_WIDTH-1:0]  iter_q [NPORT];
    logic [CNT_WIDTH-1:0]  iter_d [NPORT];
    logic [CNT_WIDTH-1:0]  schedOff_q [NPORT];
    logic [CNT_WIDTH-1:0]  schedOff_d [NPORT];
    logic [ADDR_WIDTH-1:0] addrOff_q [NPORT];
    logic [ADDR_WIDTH-1:0] addrOff_d [NPORT];

    logic [CNT_WIDTH-1:0]  cfgExt [NPORT];
    logic [CNT_WIDTH-1:0]  cfgCycStride [NPORT];
    logic [ADDR_WIDTH-1:0] cfgAddrStride [NPORT];
    logic [CNT_WIDTH-1:0]  iterLim [NPORT];
    int                    dimEff;

    logic [CNT_WIDTH-1:0]  iterAdv [NPORT];
    logic [CNT_WIDTH-1:0]  schedOffAdv [NPORT];
    logic [ADDR_WIDTH-1:0] addrOffAdv [NPORT];
    logic [CNT_WIDTH-1:0]  schedAdv;
    logic [ADDR_WIDTH-1:0] addrAdv;
    logic                  allAtMax;
    logic                  carry;

    // This block gathers the per-dimension configuration into arrays and
    // finds the last index of each iterator. An extent of 0 behaves like
    // 1, so the last index is 0. The active depth is clamped to the depth
    // the hardware supports.
    always_comb begin
        cfgExt[0]        = config_extent_0_i;
        cfgExt[1]        = config_extent_1_i;
        cfgExt[2]        = config_extent_2_i;
        cfgCycStride[0]  = config_cycle_stride_0_i;
        cfgCycStride[1]  = config_cycle_stride_1_i;
        cfgCycStride[2]  = config_cycle_stride_2_i;
        cfgAddrStride[0] = config_addr_stride_0_i;
        cfgAddrStride[1] = config_addr_stride_1_i;
        cfgAddrStride[2] = config_addr_stride_2_i;
        for (int d = 0; d < NPORT; d++) begin
            iterLim[d] = (cfgExt[d] == '0) ? '0 : (cfgExt[d] - CNT_ONE);
        end
        dimEff = int'(config_dimensionality_i);
        if (dimEff > DIMS) begin
            dimEff = DIMS;
        end
        if (dimEff > NPORT) begin
            dimEff = NPORT;
        end
    end

    // This block works out the next iteration point, acting like an
    // odometer. The first active iterator that is not at its limit
    // advances, and every active iterator below it wraps to 0. A wrapping
    // dimension drops its accumulated offsets back to 0. The advancing
    // dimension adds one stride to its offsets. allAtMax marks the final
    // point of the nest. Inactive dimensions are never touched, so their
    // offsets stay at the 0 they were loaded with.
    always_comb begin
        carry    = 1'b1;
        allAtMax = 1'b1;
        for (int d = 0; d < NPORT; d++) begin
            iterAdv[d]     = iter_q[d];
            schedOffAdv[d] = schedOff_q[d];
            addrOffAdv[d]  = addrOff_q[d];
            if (d < dimEff) begin
                if (iter_q[d] != iterLim[d]) begin
                    allAtMax = 1'b0;
                end
                if (carry) begin
                    if (iter_q[d] == iterLim[d]) begin
                        iterAdv[d]     = '0;
                        schedOffAdv[d] = '0;
                        addrOffAdv[d]  = '0;
                    end else begin
                        iterAdv[d]     = iter_q[d] + CNT_ONE;
                        schedOffAdv[d] = schedOff_q[d] + cfgCycStride[d];
                        addrOffAdv[d]  = addrOff_q[d] + cfgAddrStride[d];
                        carry          = 1'b0;
                    end
                end
            end
        end
        schedAdv = config_cycle_start_i;
        addrAdv  = config_addr_start_i;
        for (int d = 0; d < NPORT; d++) begin
            schedAdv = schedAdv + schedOffAdv[d];
            addrAdv  = addrAdv + addrOffAdv[d];
        end
    end

    // The strobe is combinational from registered state, so it fires in
    // the same cycle the counter reaches the schedule point. A point the
    // counter has already passed waits until the counter wraps back to it.
    assign step_o = (state_q == RUN) && (cycCnt_q == sched_q);
    assign last_o = step_o && allAtMax;
    assign addr_o = addr_q;
    assign done_o = done_q;

    // This block holds the next-state and datapath-load logic. Flush takes
    // priority over every state. A step in the same cycle as a flush or an
    // enable drop still shows on the outputs, but the iterators do not
    // advance. The final step moves to DONE without advancing, because
    // nothing reads the iterators after that point.
    always_comb begin
        state_d  = state_q;
        cycCnt_d = cycCnt_q;
        sched_d  = sched_q;
        addr_d   = addr_q;
        done_d   = done_q;
        for (int d = 0; d < NPORT; d++) begin
            iter_d[d]     = iter_q[d];
            schedOff_d[d] = schedOff_q[d];
            addrOff_d[d]  = addrOff_q[d];
        end

        if (flush_i) begin
            state_d  = IDLE;
            cycCnt_d = '0;
            sched_d  = '0;
            addr_d   = '0;
            done_d   = 1'b0;
            for (int d = 0; d < NPORT; d++) begin
                iter_d[d]     = '0;
                schedOff_d[d] = '0;
                addrOff_d[d]  = '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (config_enable_i && (config_dimensionality_i != 2'd0)) begin
                        state_d  = RUN;
                        cycCnt_d = '0;
                        sched_d  = config_cycle_start_i;
                        addr_d   = config_addr_start_i;
                        done_d   = 1'b0;
                        for (int d = 0; d < NPORT; d++) begin
                            iter_d[d]     = '0;
                            schedOff_d[d] = '0;
                            addrOff_d[d]  = '0;
                        end
                    end
                end
                RUN: begin
                    if (!config_enable_i) begin
                        state_d  = IDLE;
                        cycCnt_d = '0;
                        done_d   = 1'b0;
                        for (int d = 0; d < NPORT; d++) begin
                            iter_d[d]     = '0;
                            schedOff_d[d] = '0;
                            addrOff_d[d]  = '0;
                        end
                    end else begin
                        cycCnt_d = cycCnt_q + CNT_ONE;
                        if (step_o) begin
                            if (allAtMax) begin
                                state_d = DONE;
                                done_d  = 1'b1;
                            end else begin
                                sched_d = schedAdv;
                                addr_d  = addrAdv;
                                for (int d = 0; d < NPORT; d++) begin
                                    iter_d[d]     = iterAdv[d];
                                    schedOff_d[d] = schedOffAdv[d];
                                    addrOff_d[d]  = addrOffAdv[d];
                                end
                            end
                        end
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // This block holds the state register. The synchronous reset overrides
    // flush, enable and any state, including the middle of a run.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            cycCnt_q <= '0;
            sched_q  <= '0;
            addr_q   <= '0;
            done_q   <= 1'b0;
            for (int d = 0; d < NPORT; d++) begin
                iter_q[d]     <= '0;
                schedOff_q[d] <= '0;
                addrOff_q[d]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            cycCnt_q <= cycCnt_d;
            sched_q  <= sched_d;
            addr_q   <= addr_d;
            done_q   <= done_d;
            for (int d = 0; d < NPORT; d++) begin
                iter_q[d]     <= iter_d[d];
                schedOff_q[d] <= schedOff_d[d];
                addrOff_q[d]  <= addrOff_d[d];
            end
        end
    end

endmodule

// File: tb/tb_lake_sched_addr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lake_sched_addr_ctrl
//
// This bench drives directed and random loop nests into
// lake_sched_addr_ctrl. A reference model turns the linear index of each
// iteration point into its iterators by division and remainder. It then
// computes the schedule time and address of that point directly from the
// affine formulas. Each cycle the bench compares the outputs with what the
// model expects.
// ---------------------------------------------------------------------------
module tb_lake_sched_addr_ctrl;

    localparam int CW = 16;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rstN;
    logic          flush;
    logic          enable;
    logic [1:0]    dim;
    logic [CW-1:0] ext [3];
    logic [CW-1:0] cycStart;
    logic [CW-1:0] cycStride [3];
    logic [AW-1:0] addrStart;
    logic [AW-1:0] addrStride [3];
    logic          step;
    logic [AW-1:0] addr;
    logic          last;
    logic          done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lake_sched_addr_ctrl #(.DIMS(3), .CNT_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
        .clk_i                   (clk),
        .rst_n_i                 (rstN),
        .flush_i                 (flush),
        .config_enable_i         (enable),
        .config_dimensionality_i (dim),
        .config_extent_0_i       (ext[0]),
        .config_extent_1_i       (ext[1]),
        .config_extent_2_i       (ext[2]),
        .config_cycle_start_i    (cycStart),
        .config_cycle_stride_0_i (cycStride[0]),
        .config_cycle_stride_1_i (cycStride[1]),
        .config_cycle_stride_2_i (cycStride[2]),
        .config_addr_start_i     (addrStart),
        .config_addr_stride_0_i  (addrStride[0]),
        .config_addr_stride_1_i  (addrStride[1]),
        .config_addr_stride_2_i  (addrStride[2]),
        .step_o                  (step),
        .addr_o                  (addr),
        .last_o                  (last),
        .done_o                  (done)
    );

    // Compares one observed value with its expected value and tallies it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic longint effExt(input int d);
        return (ext[d] == 0) ? 1 : longint'(ext[d]);
    endfunction

    function automatic int totalPoints();
        longint t = 1;
        for (int d = 0; d < int'(dim); d++) t = t * effExt(d);
        return int'(t);
    endfunction

    // Returns the schedule time or the address of linear point k, where
    // dimension 0 varies fastest.
    function automatic longint pointValue(input int k, input bit wantAddr);
        longint rem = k;
        longint acc = wantAddr ? longint'(addrStart) : longint'(cycStart);
        for (int d = 0; d < int'(dim); d++) begin
            longint it = rem % effExt(d);
            rem = rem / effExt(d);
            acc = acc + it * (wantAddr ? longint'(addrStride[d]) : longint'(cycStride[d]));
        end
        return wantAddr ? (acc % (longint'(1) << AW)) : (acc % (longint'(1) << CW));
    endfunction

    // Loads a configuration and raises enable. The call is made just after
    // a falling edge, while the design is in IDLE.
    task automatic applyStimulus(input int d, input int e0, input int e1, input int e2,
                                 input int cs, input int s0, input int s1, input int s2,
                                 input int as, input int a0, input int a1, input int a2);
        dim           = 2'(d);
        ext[0]        = CW'(e0);
        ext[1]        = CW'(e1);
        ext[2]        = CW'(e2);
        cycStart      = CW'(cs);
        cycStride[0]  = CW'(s0);
        cycStride[1]  = CW'(s1);
        cycStride[2]  = CW'(s2);
        addrStart     = AW'(as);
        addrStride[0] = AW'(a0);
        addrStride[1] = AW'(a1);
        addrStride[2] = AW'(a2);
        enable        = 1'b1;
    endtask

    // Follows one run from IDLE, checking every cycle at the falling edge.
    // If abortAt is not negative, the run is cut short at that counter
    // value: kind 0 flushes, kind 1 resets, kind 2 drops enable.
    task automatic runAndCheck(input int budget, input int abortAt, input int abortKind);
        int  c = 0;
        int  k = 0;
        int  total = totalPoints();
        bit  finished = 0;
        bit  expStep;
        @(posedge clk);
        for (int n = 0; n < budget && !finished; n++) begin
            @(negedge clk);
            if (k >= total) begin
                checkOutput("doneSet", done, 1);
                checkOutput("stepInDone", step, 0);
                finished = 1;
            end else begin
                expStep = (longint'(c) == pointValue(k, 0));
                checkOutput("step", step, expStep);
                checkOutput("last", last, expStep && (k == total - 1));
                checkOutput("doneLow", done, 0);
                if (expStep) begin
                    checkOutput("addr", addr, 32'(pointValue(k, 1)));
                    k++;
                end
                if (c == abortAt) begin
                    if (abortKind == 0) flush = 1'b1;
                    else if (abortKind == 1) begin rstN = 1'b0; enable = 1'b0; end
                    else enable = 1'b0;
                    @(negedge clk);
                    checkOutput("abortStep", step, 0);
                    checkOutput("abortLast", last, 0);
                    checkOutput("abortDone", done, 0);
                    if (abortKind == 1) checkOutput("abortAddr", addr, 0);
                    flush    = 1'b0;
                    rstN     = 1'b1;
                    finished = 1;
                end
                c = (c + 1) % 65536;
            end
        end
        if (!finished) checkOutput("cycleBudget", 0, 1);
    endtask

    // Returns the design to IDLE through a flush, with enable low.
    task automatic restart();
        @(negedge clk);
        enable = 1'b0;
        flush  = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("restartDone", done, 0);
        checkOutput("restartStep", step, 0);
    endtask

    initial begin
        rstN   = 1'b0;
        flush  = 1'b0;
        enable = 1'b1;
        applyStimulus(1, 4, 0, 0, 2, 3, 0, 0, 5, 1, 0, 0);
        repeat (3) @(negedge clk);
        checkOutput("resetStep", step, 0);
        checkOutput("resetLast", last, 0);
        checkOutput("resetDone", done, 0);
        checkOutput("resetAddr", addr, 0);
        rstN = 1'b1;

        $display("[TB] 1D nest");
        runAndCheck(100, -1, 0);

        $display("[TB] flush mid-run, then rerun");
        restart();
        applyStimulus(1, 4, 0, 0, 2, 3, 0, 0, 5, 1, 0, 0);
        runAndCheck(100, 6, 0);
        runAndCheck(100, -1, 0);

        $display("[TB] 2D nest");
        restart();
        applyStimulus(2, 2, 3, 0, 0, 1, 4, 0, 0, 1, 10, 0);
        runAndCheck(100, -1, 0);

        $display("[TB] reset mid-run, enable low holds idle");
        restart();
        applyStimulus(2, 2, 3, 0, 0, 1, 4, 0, 0, 1, 10, 0);
        runAndCheck(100, 5, 1);
        repeat (4) begin
            @(negedge clk);
            checkOutput("holdIdleStep", step, 0);
            checkOutput("holdIdleDone", done, 0);
        end

        $display("[TB] enable drop mid-run");
        applyStimulus(2, 3, 3, 0, 1, 2, 7, 0, 3, 4, 100, 0);
        runAndCheck(100, 4, 2);

        $display("[TB] zero extent and address wrap");
        restart();
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 7, 1, 0, 0);
        runAndCheck(20, -1, 0);
        restart();
        applyStimulus(1, 4, 0, 0, 0, 1, 0, 0, 510, 1, 0, 0);
        runAndCheck(20, -1, 0);

        $display("[TB] random nests");
        for (int t = 0; t < 8; t++) begin
            int d  = int'($urandom_range(1, 3));
            int e0 = int'($urandom_range(0, 3));
            int e1 = int'($urandom_range(0, 3));
            int e2 = int'($urandom_range(0, 3));
            int f0 = (e0 == 0) ? 1 : e0;
            int f1 = (e1 == 0) ? 1 : e1;
            int s0 = int'($urandom_range(1, 3));
            int s1 = (f0 - 1) * s0 + int'($urandom_range(1, 3));
            int s2 = (f1 - 1) * s1 + int'($urandom_range(1, 3));
            if (d < 3) begin e2 = int'($urandom_range(0, 65535)); s2 = int'($urandom_range(0, 65535)); end
            if (d < 2) begin e1 = int'($urandom_range(0, 65535)); s1 = int'($urandom_range(0, 65535)); end
            restart();
            applyStimulus(d, e0, e1, e2, int'($urandom_range(0, 5)), s0, s1, s2,
                          int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
                          int'($urandom_range(0, 511)), int'($urandom_range(0, 511)));
            runAndCheck(300, -1, 0);
        end

        $display("[TB] late first step at top of counter range");
        restart();
        applyStimulus(1, 0, 0, 0, 65535, 1, 0, 0, 9, 1, 0, 0);
        runAndCheck(70000, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
